// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and FSM state encoding for the regfile writeback arbiter.
// Package items are used by regfile_wb_arbiter and regarb_scoreboard.
package regfile_wb_arbiter_pkg;
  localparam int DWORD_DEF = 32;
  localparam logic [4:0] REG_ZERO = 5'b00000;

  typedef enum logic [1:0] {
    RA_IDLE  = 2'b00,
    RA_WAIT  = 2'b01,
    RA_FORCE = 2'b10
  } ra_state_e;
endpackage

// File: rtl/regarb_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// r0 can never be busy because writes to it are discarded.
module regarb_scoreboard
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int AWIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_en,
  input  logic [AWIDTH-1:0]        clr_addr,
  input  logic                     set_en,
  input  logic [AWIDTH-1:0]        set_addr,
  output logic [(1<<AWIDTH)-1:0]   busy
);
  localparam int NREG = 1 << AWIDTH;

  logic [NREG-1:0] busy_q, busy_d;

  // Clear first, then set, so a retiring op and a new op to the same
  // register leave the register marked busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy = busy_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single regfile write port between WB (fixed priority) and the
// multi-cycle unit. Starvation guard FSM is built only with REGARB_STARVE_GUARD_EN.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DWORD    = DWORD_DEF,
  parameter int AWIDTH   = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_w,
  input  logic [AWIDTH-1:0]      wb_addr,
  input  logic [DWORD-1:0]       wb_data,
  input  logic                   mc_issue,
  input  logic [AWIDTH-1:0]      mc_issue_addr,
  input  logic                   mc_valid,
  input  logic [AWIDTH-1:0]      mc_addr,
  input  logic [DWORD-1:0]       mc_data,
  output logic                   mc_ready,
  output logic                   rf_w,
  output logic [AWIDTH-1:0]      rf_w_addr,
  output logic [DWORD-1:0]       rf_w_data,
  output logic [(1<<AWIDTH)-1:0] busy,
  output logic                   pipe_stall
);
  if (MAX_WAIT < 1) begin : g_bad_cfg
    $error("regfile_wb_arbiter: MAX_WAIT must be at least 1");
  end

  logic mc_xfer;

  // WB always owns the port; FORCE only freezes WB upstream, so the grant
  // rule is identical with or without the starvation guard.
  assign mc_ready = !rst && !wb_w;
  assign mc_xfer  = mc_valid && mc_ready;

  logic                rf_w_q;
  logic [AWIDTH-1:0]   rf_w_addr_q;
  logic [DWORD-1:0]    rf_w_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_w_q      <= 1'b0;
      rf_w_addr_q <= '0;
      rf_w_data_q <= '0;
    end else if (wb_w) begin
      rf_w_q      <= (wb_addr != AWIDTH'(REG_ZERO));
      rf_w_addr_q <= wb_addr;
      rf_w_data_q <= wb_data;
    end else if (mc_xfer) begin
      rf_w_q      <= (mc_addr != AWIDTH'(REG_ZERO));
      rf_w_addr_q <= mc_addr;
      rf_w_data_q <= mc_data;
    end else begin
      rf_w_q      <= 1'b0;
    end
  end

  assign rf_w      = rf_w_q;
  assign rf_w_addr = rf_w_addr_q;
  assign rf_w_data = rf_w_data_q;

  regarb_scoreboard #(.AWIDTH(AWIDTH)) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .clr_en   (mc_xfer),
    .clr_addr (mc_addr),
    .set_en   (mc_issue),
    .set_addr (mc_issue_addr),
    .busy     (busy)
  );

`ifdef REGARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  ra_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stalled;

  assign stalled = mc_valid && !mc_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RA_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The IDLE stalled cycle counts as the first one, so FORCE is reached
  // after exactly MAX_WAIT consecutive stalled cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RA_IDLE: begin
        if (stalled) begin
          state_d = (MAX_WAIT <= 1) ? RA_FORCE : RA_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      RA_WAIT: begin
        if (mc_xfer || !mc_valid) begin
          state_d = RA_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
          state_d = RA_FORCE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RA_FORCE: begin
        if (mc_xfer) begin
          state_d = RA_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = RA_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign pipe_stall = (state_q == RA_FORCE);
`else
  assign pipe_stall = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a queue scoreboard tracks the
// registered write port, scenario tasks check handshake, scoreboard and guard.
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        wb_w;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mc_issue;
  logic [4:0]  mc_issue_addr;
  logic        mc_valid;
  logic [4:0]  mc_addr;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic        rf_w;
  logic [4:0]  rf_w_addr;
  logic [31:0] rf_w_data;
  logic [31:0] busy;
  logic        pipe_stall;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        w;
    logic        full;
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;
  exp_t exp_q[$];

  regfile_wb_arbiter #(.DWORD(32), .AWIDTH(5), .MAX_WAIT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .wb_w          (wb_w),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .mc_issue      (mc_issue),
    .mc_issue_addr (mc_issue_addr),
    .mc_valid      (mc_valid),
    .mc_addr       (mc_addr),
    .mc_data       (mc_data),
    .mc_ready      (mc_ready),
    .rf_w          (rf_w),
    .rf_w_addr     (rf_w_addr),
    .rf_w_data     (rf_w_data),
    .busy          (busy),
    .pipe_stall    (pipe_stall)
  );

  always #5 clk = ~clk;

  // Push the expected write-port result of the current inputs, advance one
  // edge, then pop and compare against the registered outputs.
  task automatic tick();
    exp_t e;
    e.w = 1'b0; e.full = 1'b0; e.a = '0; e.d = '0;
    if (rst) begin
      e.full = 1'b1;
    end else if (wb_w) begin
      e.w = (wb_addr != 5'd0);
      e.full = e.w; e.a = wb_addr; e.d = wb_data;
    end else if (mc_valid) begin
      e.w = (mc_addr != 5'd0);
      e.full = e.w; e.a = mc_addr; e.d = mc_data;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (rf_w !== e.w || (e.full && (rf_w_addr !== e.a || rf_w_data !== e.d))) begin
      failures++;
      $display("FAIL rf_port: got w=%b addr=%0d data=%h, expected w=%b addr=%0d data=%h",
               rf_w, rf_w_addr, rf_w_data, e.w, e.a, e.d);
    end
  endtask

  task automatic idle_inputs();
    wb_w = 1'b0; wb_addr = '0; wb_data = '0;
    mc_issue = 1'b0; mc_issue_addr = '0;
    mc_valid = 1'b0; mc_addr = '0; mc_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; wb_w = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234_5678;
    mc_valid = 1'b1; mc_addr = 5'd6; mc_data = 32'h9;
    mc_issue = 1'b1; mc_issue_addr = 5'd8;
    #1;
    checks++;
    if (mc_ready !== 1'b0) begin
      failures++; $display("FAIL reset_mc_ready: got %b expected 0", mc_ready);
    end
    tick();
    tick();
    checks++;
    if (busy !== 32'h0 || pipe_stall !== 1'b0) begin
      failures++; $display("FAIL reset_state: busy=%h stall=%b expected 0/0", busy, pipe_stall);
    end
    rst = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (mc_ready !== 1'b1) begin
      failures++; $display("FAIL idle_mc_ready: got %b expected 1", mc_ready);
    end
    tick();
  endtask

  task automatic test_wb_write();
    wb_w = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (rf_w !== 1'b1 || rf_w_addr !== 5'd3 || rf_w_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL wb_write: got w=%b addr=%0d data=%h expected 1/3/deadbeef", rf_w, rf_w_addr, rf_w_data);
    end
    idle_inputs();
    tick();
    checks++;
    if (rf_w !== 1'b0) begin
      failures++; $display("FAIL wb_write_drop: got rf_w=%b expected 0", rf_w);
    end
  endtask

  task automatic test_mc_transfer();
    mc_issue = 1'b1; mc_issue_addr = 5'd7;
    tick();
    checks++;
    if (busy !== 32'h0000_0080) begin
      failures++; $display("FAIL busy_set: got %h expected 00000080", busy);
    end
    mc_issue = 1'b0;
    tick();
    mc_valid = 1'b1; mc_addr = 5'd7; mc_data = 32'h55;
    #1;
    checks++;
    if (mc_ready !== 1'b1) begin
      failures++; $display("FAIL mc_ready_free: got %b expected 1", mc_ready);
    end
    tick();
    checks++;
    if (busy !== 32'h0 || rf_w_addr !== 5'd7 || rf_w_data !== 32'h55) begin
      failures++;
      $display("FAIL mc_retire: busy=%h addr=%0d data=%h expected 0/7/55", busy, rf_w_addr, rf_w_data);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_same_addr();
    mc_issue = 1'b1; mc_issue_addr = 5'd9;
    tick();
    mc_valid = 1'b1; mc_addr = 5'd9; mc_data = 32'hA5A5_0009;
    tick();
    checks++;
    if (busy !== 32'h0000_0200) begin
      failures++; $display("FAIL set_wins: got busy=%h expected 00000200", busy);
    end
    mc_valid = 1'b0; mc_issue_addr = 5'd0;
    tick();
    checks++;
    if (busy !== 32'h0000_0200) begin
      failures++; $display("FAIL busy_r0: got busy=%h expected 00000200", busy);
    end
    mc_issue = 1'b0; mc_valid = 1'b1; mc_addr = 5'd9; mc_data = 32'h99;
    tick();
    checks++;
    if (busy !== 32'h0) begin
      failures++; $display("FAIL busy_clear9: got busy=%h expected 0", busy);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    // WB streams while MC waits; MC goes the first free cycle.
    mc_valid = 1'b1; mc_addr = 5'd12; mc_data = 32'hC0C0_0012;
    for (int i = 0; i < 3; i++) begin
      wb_w = 1'b1; wb_addr = 5'(i + 20); wb_data = 32'h100 + 32'(i);
      #1;
      checks++;
      if (mc_ready !== 1'b0) begin
        failures++; $display("FAIL b2b_ready[%0d]: got %b expected 0", i, mc_ready);
      end
      tick();
    end
    wb_w = 1'b0;
    tick();
    checks++;
    if (rf_w !== 1'b1 || rf_w_addr !== 5'd12) begin
      failures++; $display("FAIL b2b_mc: got w=%b addr=%0d expected 1/12", rf_w, rf_w_addr);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_starve();
    wb_w = 1'b1; wb_addr = 5'd2; wb_data = 32'h22;
    mc_valid = 1'b1; mc_addr = 5'd4; mc_data = 32'h4444;
`ifdef REGARB_STARVE_GUARD_EN
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (pipe_stall !== (i == 4)) begin
        failures++; $display("FAIL stall_cycle%0d: got %b expected %b", i, pipe_stall, (i == 4));
      end
    end
`else
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (pipe_stall !== 1'b0 || mc_ready !== 1'b0) begin
        failures++; $display("FAIL starve%0d: stall=%b ready=%b expected 0/0", i, pipe_stall, mc_ready);
      end
    end
`endif
    wb_w = 1'b0;
    #1;
    checks++;
    if (mc_ready !== 1'b1) begin
      failures++; $display("FAIL starve_accept: got %b expected 1", mc_ready);
    end
    tick();
    checks++;
    if (pipe_stall !== 1'b0 || rf_w_addr !== 5'd4 || rf_w_data !== 32'h4444) begin
      failures++;
      $display("FAIL starve_release: stall=%b addr=%0d data=%h expected 0/4/4444", pipe_stall, rf_w_addr, rf_w_data);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_r0();
    wb_w = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    tick();
    checks++;
    if (rf_w !== 1'b0) begin
      failures++; $display("FAIL wb_r0: got rf_w=%b expected 0", rf_w);
    end
    wb_w = 1'b0;
    mc_issue = 1'b1; mc_issue_addr = 5'd10;
    tick();
    mc_issue = 1'b0;
    mc_valid = 1'b1; mc_addr = 5'd0; mc_data = 32'h0BAD;
    #1;
    checks++;
    if (mc_ready !== 1'b1) begin
      failures++; $display("FAIL mc_r0_ready: got %b expected 1", mc_ready);
    end
    tick();
    checks++;
    if (rf_w !== 1'b0 || busy !== 32'h0000_0400) begin
      failures++; $display("FAIL mc_r0: rf_w=%b busy=%h expected 0/00000400", rf_w, busy);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_wb_write();
    test_mc_transfer();
    test_same_addr();
    test_back_to_back();
    test_starve();
    test_r0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
